gbe_txof_ctrl: RTL and testbench

Transmit-overflow controller for the 10GbE core's TX path, clocked in the user clock domain. It counts TX overflow events into a counter that drives the `user_data_in` port of the `gbe0_txofctr` software register. On overflow it sequences recovery:

- drops the remainder of the in-flight frame;
- pulses the core's TX reset;
- holds off traffic for a fixed number of cycles;
- readmits frames only on a frame boundary.

Software controls it through one 32-bit control word from a ppc2simulink register.

---
 rtl/gbe_txof_if.sv | 30 +++
 rtl/gbe_txof_ctrl.sv | 141 ++++++++++++++
 tb/tb_gbe_txof_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gbe_txof_if.sv
// gbe_txof_if: signal bundle between the TX overflow controller and its environment.
//   ctrl_in      : software control word (bit0 cnt_en, bit1 clr, bit2 auto_rec, bit3 man_rec)
//   tx_overflow  : overflow level from the 10GbE core
//   tx_valid_in  : application frame valid
//   tx_eof_in    : application end-of-frame, qualified by tx_valid_in
//   tx_valid_out : gated valid towards the core
//   gbe_rst      : TX reset towards the core
//   ctr_out      : overflow event count (to the gbe0_txofctr user_data_in port)
//   state_out    : controller state, for debug
// Modports: master drives the inputs and observes the outputs; slave is the controller.
interface gbe_txof_if;
    logic [31:0] ctrl_in;
    logic        tx_overflow;
    logic        tx_valid_in;
    logic        tx_eof_in;
    logic        tx_valid_out;
    logic        gbe_rst;
    logic [31:0] ctr_out;
    logic [2:0]  state_out;

    modport master (
        output ctrl_in, tx_overflow, tx_valid_in, tx_eof_in,
        input  tx_valid_out, gbe_rst, ctr_out, state_out
    );

    modport slave (
        input  ctrl_in, tx_overflow, tx_valid_in, tx_eof_in,
        output tx_valid_out, gbe_rst, ctr_out, state_out
    );
endinterface

// File: rtl/gbe_txof_ctrl.sv
// gbe_txof_ctrl: TX overflow controller for the 10GbE core, user_clk domain.
// Counts overflow events and sequences recovery: drain the in-flight frame, pulse the core
// TX reset for RST_CYCLES, hold off traffic for HOLDOFF cycles, resume on a frame boundary.
// Ports:
//   user_clk   : clock, rising edge
//   user_rst_n : asynchronous active-low reset
//   bus        : gbe_txof_if.slave (control word, overflow flag, TX stream, status outputs)
// Build option: define GBE_TXOF_SAT_EN to make the counter saturate at all-ones instead of
// wrapping.
module gbe_txof_ctrl #(
    parameter int unsigned CTR_WIDTH  = 32,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned HOLDOFF    = 64
) (
    input logic        user_clk,
    input logic        user_rst_n,
    gbe_txof_if.slave  bus
);

    typedef enum logic [2:0] {
        StRun   = 3'd0,
        StDrain = 3'd1,
        StReset = 3'd2,
        StHold  = 3'd3,
        StHalt  = 3'd4
    } state_e;

    localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] HoldLast = 16'(HOLDOFF - 1);

    state_e               state_q, state_d;
    logic [15:0]          cyc_q, cyc_d;
    logic                 in_frame_q, in_frame_d;
    logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
    logic                 gbe_rst_q;
    logic                 ovf_q, ovf_prev_q;
    logic                 clr_q, clr_prev_q;
    logic                 man_q, man_prev_q;

    logic cnt_en, auto_rec;
    logic ovf_evt, clr_evt, man_evt;
    logic eof_beat;
    logic unused_ctrl;

    assign cnt_en   = bus.ctrl_in[0];
    assign auto_rec = bus.ctrl_in[2];
    assign unused_ctrl = ^bus.ctrl_in[31:4];

    // Events compare the registered sample against the previous sample, so an overflow
    // first sampled at edge N acts at edge N+1.
    assign ovf_evt = ovf_q & ~ovf_prev_q;
    assign clr_evt = clr_q & ~clr_prev_q;
    assign man_evt = man_q & ~man_prev_q;

    assign eof_beat = bus.tx_valid_in & bus.tx_eof_in;

    always_comb begin
        in_frame_d = in_frame_q;
        if (bus.tx_valid_in) begin
            in_frame_d = ~bus.tx_eof_in;
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (clr_evt) begin
            ctr_d = '0;
        end else if (ovf_evt && cnt_en) begin
`ifdef GBE_TXOF_SAT_EN
            if (ctr_q != {CTR_WIDTH{1'b1}}) begin
                ctr_d = ctr_q + 1'b1;
            end
`else
            ctr_d = ctr_q + 1'b1;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            StRun: begin
                if (ovf_evt) state_d = StDrain;
            end
            StDrain: begin
                if (!in_frame_q || eof_beat) state_d = auto_rec ? StReset : StHalt;
            end
            StReset: begin
                if (cyc_q == RstLast) state_d = StHold;
                else                  cyc_d   = cyc_q + 16'd1;
            end
            StHold: begin
                // Count stops at the end of holdoff; then wait for an idle cycle.
                if (cyc_q != HoldLast)                       cyc_d   = cyc_q + 16'd1;
                else if (!in_frame_q && !bus.tx_valid_in)    state_d = StRun;
            end
            StHalt: begin
                if (man_evt) state_d = StReset;
            end
            default: state_d = StReset;
        endcase
        if (state_d != state_q) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q    <= StReset;
            cyc_q      <= '0;
            in_frame_q <= 1'b0;
            ctr_q      <= '0;
            gbe_rst_q  <= 1'b1;
            ovf_q      <= 1'b0;
            ovf_prev_q <= 1'b0;
            clr_q      <= 1'b0;
            clr_prev_q <= 1'b0;
            man_q      <= 1'b0;
            man_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            in_frame_q <= in_frame_d;
            ctr_q      <= ctr_d;
            gbe_rst_q  <= (state_d == StReset);
            ovf_q      <= bus.tx_overflow;
            ovf_prev_q <= ovf_q;
            clr_q      <= bus.ctrl_in[1];
            clr_prev_q <= clr_q;
            man_q      <= bus.ctrl_in[3];
            man_prev_q <= man_q;
        end
    end

    assign bus.tx_valid_out = (state_q == StRun) & bus.tx_valid_in;
    assign bus.gbe_rst      = gbe_rst_q;
    assign bus.ctr_out      = 32'(ctr_q);
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_gbe_txof_ctrl.sv
module tb_gbe_txof_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    gbe_txof_if bus ();

    gbe_txof_ctrl #(
        .CTR_WIDTH  (4),
        .RST_CYCLES (16),
        .HOLDOFF    (64)
    ) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] sat_exp;
`ifdef GBE_TXOF_SAT_EN
        sat_exp = 32'd15;
`else
        sat_exp = 32'd1;
`endif
        rst_n           = 1'b1;
        bus.ctrl_in     = 32'h0;
        bus.tx_overflow = 1'b0;
        bus.tx_valid_in = 1'b0;
        bus.tx_eof_in   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gbe_rst", {31'd0, bus.gbe_rst}, 32'd1);
        chk("rst_ctr", bus.ctr_out, 32'd0);
        chk("rst_state", {29'd0, bus.state_out}, 32'd2);
        bus.tx_valid_in = 1'b1;
        #1;
        chk("rst_vout", {31'd0, bus.tx_valid_out}, 32'd0);
        bus.tx_valid_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Power-up: 16 cycles of core reset, 64 of holdoff, then RUN.
        for (int i = 0; i < 16; i++) begin
            chk("pwr_gbe_rst", {31'd0, bus.gbe_rst}, 32'd1);
            chk("pwr_state_rst", {29'd0, bus.state_out}, 32'd2);
            tick();
        end
        chk("pwr_gbe_rst_off", {31'd0, bus.gbe_rst}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            chk("pwr_state_hold", {29'd0, bus.state_out}, 32'd3);
            tick();
        end
        chk("pwr_state_run", {29'd0, bus.state_out}, 32'd0);
        chk("pwr_ctr", bus.ctr_out, 32'd0);

        // Auto recovery: overflow mid-way through a 10-beat frame.
        bus.ctrl_in = 32'h5;
        tick();
        for (int c = 0; c < 92; c++) begin
            bus.tx_valid_in = (c < 10) || (c == 30) || (c >= 90);
            bus.tx_eof_in   = (c == 9) || (c == 30) || (c >= 90);
            bus.tx_overflow = (c >= 4) && (c <= 6);
            #1;
            if (c == 5) begin
                chk("auto_last_beat", {31'd0, bus.tx_valid_out}, 32'd1);
                chk("auto_ctr_pre", bus.ctr_out, 32'd0);
            end
            if (c == 6) begin
                chk("auto_drain", {29'd0, bus.state_out}, 32'd1);
                chk("auto_blocked", {31'd0, bus.tx_valid_out}, 32'd0);
                chk("auto_ctr", bus.ctr_out, 32'd1);
            end
            if (c == 8) chk("auto_ctr_level", bus.ctr_out, 32'd1);
            if (c == 9) chk("auto_drain_eof", {29'd0, bus.state_out}, 32'd1);
            if (c == 10) chk("auto_reset", {29'd0, bus.state_out}, 32'd2);
            if (c == 10) chk("auto_gbe_on", {31'd0, bus.gbe_rst}, 32'd1);
            if (c == 25) chk("auto_gbe_last", {31'd0, bus.gbe_rst}, 32'd1);
            if (c == 26) begin
                chk("auto_hold", {29'd0, bus.state_out}, 32'd3);
                chk("auto_gbe_off", {31'd0, bus.gbe_rst}, 32'd0);
            end
            if (c == 30) chk("auto_hold_blocked", {31'd0, bus.tx_valid_out}, 32'd0);
            if (c == 89) chk("auto_hold_end", {29'd0, bus.state_out}, 32'd3);
            if (c == 90) begin
                chk("auto_run", {29'd0, bus.state_out}, 32'd0);
                chk("auto_pass", {31'd0, bus.tx_valid_out}, 32'd1);
            end
            tick();
        end
        bus.tx_valid_in = 1'b0;
        bus.tx_eof_in   = 1'b0;
        bus.tx_overflow = 1'b0;

        // Manual recovery: HALT, then man_rec edge.
        for (int c = 0; c < 90; c++) begin
            bus.tx_overflow = (c == 0);
            bus.ctrl_in     = (c >= 5) ? 32'h9 : 32'h1;
            bus.tx_valid_in = (c == 3) || (c >= 88);
            bus.tx_eof_in   = (c == 3) || (c >= 88);
            #1;
            if (c == 1) chk("man_still_run", {29'd0, bus.state_out}, 32'd0);
            if (c == 2) begin
                chk("man_drain", {29'd0, bus.state_out}, 32'd1);
                chk("man_ctr", bus.ctr_out, 32'd2);
            end
            if (c == 3) begin
                chk("man_halt", {29'd0, bus.state_out}, 32'd4);
                chk("man_halt_blocked", {31'd0, bus.tx_valid_out}, 32'd0);
                chk("man_halt_gbe", {31'd0, bus.gbe_rst}, 32'd0);
            end
            if (c == 6) chk("man_halt_wait", {29'd0, bus.state_out}, 32'd4);
            if (c == 7) chk("man_reset", {29'd0, bus.state_out}, 32'd2);
            if (c == 22) chk("man_reset_end", {31'd0, bus.gbe_rst}, 32'd1);
            if (c == 23) chk("man_hold", {29'd0, bus.state_out}, 32'd3);
            if (c == 86) chk("man_hold_end", {29'd0, bus.state_out}, 32'd3);
            if (c == 87) chk("man_run", {29'd0, bus.state_out}, 32'd0);
            if (c == 88) chk("man_pass", {31'd0, bus.tx_valid_out}, 32'd1);
            tick();
        end
        bus.tx_valid_in = 1'b0;
        bus.tx_eof_in   = 1'b0;

        // man_rec edge in RUN is ignored.
        bus.ctrl_in = 32'h1;
        tick();
        tick();
        bus.ctrl_in = 32'h9;
        tick();
        tick();
        tick();
        chk("man_ignored", {29'd0, bus.state_out}, 32'd0);
        bus.ctrl_in = 32'h1;

        // Park in HALT and bring the counter to 7, then clr races an overflow.
        bus.tx_overflow = 1'b1;
        tick();
        bus.tx_overflow = 1'b0;
        tick();
        tick();
        tick();
        chk("clr_halt", {29'd0, bus.state_out}, 32'd4);
        chk("clr_ctr3", bus.ctr_out, 32'd3);
        for (int i = 0; i < 4; i++) begin
            bus.tx_overflow = 1'b1;
            tick();
            bus.tx_overflow = 1'b0;
            tick();
        end
        chk("clr_ctr7", bus.ctr_out, 32'd7);
        bus.ctrl_in     = 32'h3;
        bus.tx_overflow = 1'b1;
        tick();
        chk("clr_pre", bus.ctr_out, 32'd7);
        bus.ctrl_in     = 32'h1;
        bus.tx_overflow = 1'b0;
        tick();
        chk("clr_wins", bus.ctr_out, 32'd0);

        // Counter limit: 15 events to all-ones, then 2 more.
        for (int i = 0; i < 15; i++) begin
            bus.tx_overflow = 1'b1;
            tick();
            bus.tx_overflow = 1'b0;
            tick();
        end
        chk("lim_ones", bus.ctr_out, 32'd15);
        for (int i = 0; i < 2; i++) begin
            bus.tx_overflow = 1'b1;
            tick();
            bus.tx_overflow = 1'b0;
            tick();
        end
        chk("lim_after", bus.ctr_out, sat_exp);

        // Asynchronous reset during HOLD.
        bus.ctrl_in = 32'h9;
        for (int i = 0; i < 25; i++) tick();
        chk("ar_hold", {29'd0, bus.state_out}, 32'd3);
        chk("ar_gbe_pre", {31'd0, bus.gbe_rst}, 32'd0);
        bus.ctrl_in = 32'h1;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_state", {29'd0, bus.state_out}, 32'd2);
        chk("ar_gbe", {31'd0, bus.gbe_rst}, 32'd1);
        chk("ar_ctr", bus.ctr_out, 32'd0);
        chk("ar_vout", {31'd0, bus.tx_valid_out}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ar_gbe_seq", {31'd0, bus.gbe_rst}, 32'd1);
            tick();
        end
        chk("ar_hold_again", {29'd0, bus.state_out}, 32'd3);
        chk("ar_gbe_end", {31'd0, bus.gbe_rst}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
